// File: rtl/c_row_streamer.sv
// Streams the rows of result matrix C out of mux_out over a valid/ready handshake.
// sel is prefetched one row ahead of out_data so rows go out back-to-back when not stalled.
module c_row_streamer #(
    parameter int DATAWIDTH = 160,
    parameter int N_SIZE    = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATAWIDTH-1:0]        row_in,
    output logic [$clog2(N_SIZE)-1:0]   sel,
    output logic [DATAWIDTH-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [$clog2(N_SIZE)-1:0]   out_row_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int SEL_W = $clog2(N_SIZE);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e               state_q;
    logic [SEL_W-1:0]     sel_q;
    logic [SEL_W-1:0]     sel_d;
    logic [DATAWIDTH-1:0] out_data_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [SEL_W-1:0]     out_row_idx_q;
    logic                 done_q;
    logic                 handshake;

    assign handshake = out_valid_q && out_ready;

    // Saturate at the last row so mux_out never selects past the end of C.
    always_comb begin
        // NOTE: default first, so every path assigns sel_d and no latch is inferred.
        sel_d = sel_q;
        if (sel_q != LAST_SEL) begin
            sel_d = sel_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_row_idx_q <= '0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        out_data_q    <= row_in;
                        out_row_idx_q <= '0;
                        out_valid_q   <= 1'b1;
                        out_last_q    <= 1'b0;
                        sel_q         <= SEL_W'(1);
                        state_q       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Without a handshake every output holds, as the valid/ready rule requires.
                    if (handshake) begin
                        if (out_last_q) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            out_data_q    <= row_in;
                            out_row_idx_q <= sel_q;
                            out_last_q    <= (sel_q == LAST_SEL);
                            sel_q         <= sel_d;
                        end
                    end
                end
                ST_DONE: begin
                    sel_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel         = sel_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_row_idx = out_row_idx_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;

endmodule
